// File: rtl/heartbeat_sequencer_if.sv
// Control and step-code bundle between the board buttons/period source and the
// heartbeat sequencer.
//
// Signals:
//   start, stop, pause  level controls into the sequencer
//   oneshot             playback mode, sampled when start is taken
//   period_in/period_ld new step period and its load strobe (honoured only in IDLE)
//   step                4-bit step code towards the pattern decoder
//   active              high while playing (RUN or PAUSE)
//   step_tick           one-cycle pulse in the cycle the step advances
//   done                one-cycle pulse on entry to DONE
//
// Modports: master drives the controls and reads the status, slave is the sequencer.
interface heartbeat_sequencer_if #(
    parameter int unsigned PRESC_W = 24
);
    logic               start;
    logic               stop;
    logic               pause;
    logic               oneshot;
    logic [PRESC_W-1:0] period_in;
    logic               period_ld;
    logic [3:0]         step;
    logic               active;
    logic               step_tick;
    logic               done;

    modport master (
        output start,
        output stop,
        output pause,
        output oneshot,
        output period_in,
        output period_ld,
        input  step,
        input  active,
        input  step_tick,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  pause,
        input  oneshot,
        input  period_in,
        input  period_ld,
        output step,
        output active,
        output step_tick,
        output done
    );
endinterface

// File: rtl/heartbeat_sequencer.sv
// Heartbeat step sequencer.
//
// Divides clk into a programmable step period and walks a 4-bit step code
// 0..NUM_STEPS-1 for the heartbeat 7-segment pattern decoder. Playback is
// either continuous (loop) or one-shot, with pause/resume and stop. The step
// period register can only be loaded while idle, so it never changes mid-play.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    heartbeat_sequencer_if.slave: controls in, step/active/step_tick/done out
//
// Parameters:
//   PRESC_W         width of the prescaler and the period register
//   DEFAULT_PERIOD  reset value of the period register (clk cycles per step)
//   NUM_STEPS       pattern length, 2..16
//
// All outputs are registered. Control priority per cycle is
// stop > pause > start > period_ld; pause only has an effect while playing.
module heartbeat_sequencer #(
    parameter int unsigned PRESC_W        = 24,
    parameter int unsigned DEFAULT_PERIOD = 12500000,
    parameter int unsigned NUM_STEPS      = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    heartbeat_sequencer_if.slave   bus
);

    localparam logic [3:0]         LAST_STEP   = 4'(NUM_STEPS - 1);
    localparam logic [PRESC_W-1:0] RESET_PERIOD = PRESC_W'(DEFAULT_PERIOD);
    localparam logic [PRESC_W-1:0] ONE          = PRESC_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic               mode_q, mode_d;
    logic               active_q, active_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;

    logic               at_period;
    logic               at_last;

    // period_q is never 0 (a load of 0 is stored as 1), so period-1 cannot wrap.
    assign at_period = (presc_q == (period_q - ONE));
    assign at_last   = (step_q == LAST_STEP);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        presc_d  = presc_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (bus.stop) begin
            // Abort wins over everything, including a coinciding tick.
            state_d = StIdle;
            step_d  = 4'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    step_d  = 4'd0;
                    presc_d = '0;
                    if (bus.start) begin
                        state_d = StRun;
                        mode_d  = bus.oneshot;
                    end else if ((state_q == StIdle) && bus.period_ld) begin
                        period_d = (bus.period_in == '0) ? ONE : bus.period_in;
                    end
                end

                StRun, StPause: begin
                    if (bus.pause) begin
                        // Freeze step and prescaler; a due tick waits for resume.
                        state_d = StPause;
                    end else begin
                        // The cycle that leaves PAUSE counts like a normal RUN
                        // cycle, so a pause costs exactly the cycles it was held.
                        state_d = StRun;
                        if (at_period) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                            if (!at_last) begin
                                step_d = step_q + 4'd1;
                            end else begin
                                step_d = 4'd0;
                                if (mode_q) begin
                                    state_d = StDone;
                                    done_d  = 1'b1;
                                end
                            end
                        end else begin
                            presc_d = presc_q + ONE;
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                    step_d  = 4'd0;
                    presc_d = '0;
                end
            endcase
        end

        active_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            step_q   <= 4'd0;
            presc_q  <= '0;
            period_q <= RESET_PERIOD;
            mode_q   <= 1'b0;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            presc_q  <= presc_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.active    = active_q;
    assign bus.step_tick = tick_q;
    assign bus.done      = done_q;

endmodule

// File: doc/heartbeat_sequencer.md
Name: heartbeat_sequencer

Overview:
- Drives the 4-bit step code into the heartbeat 7-segment pattern decoder.
- Divides the board clock into a programmable step period and walks the step code 0..NUM_STEPS-1.
- Supports continuous or one-shot playback, pause/resume and stop, with a period register loaded while idle.
- Sits between the board clock/buttons and the pattern decoder.

Parameters:
- PRESC_W, 24, width of the prescaler counter and period register.
- DEFAULT_PERIOD, 12500000, reset value of the period register in clk cycles per step (0.25 s at 50 MHz).
- NUM_STEPS, 12, pattern length; step counts 0..NUM_STEPS-1; must be 2..16.

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; in IDLE or DONE, begins playback.
- stop  input  1  level; aborts playback and returns to IDLE.
- pause  input  1  level; holds step and prescaler while high in RUN.
- oneshot  input  1  sampled on start; 1 = play one cycle then DONE, 0 = loop.
- period_in  input  PRESC_W  new step period in clk cycles.
- period_ld  input  1  loads period_in into the period register; honoured only in IDLE.
- step  output  4  step code to the pattern decoder.
- active  output  1  high in RUN or PAUSE.
- step_tick  output  1  one-cycle pulse in the cycle step advances.
- done  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state=IDLE, step=0, prescaler=0, period register=DEFAULT_PERIOD, mode=0.
  - active=0, step_tick=0, done=0.
- All outputs are registered. Step 0 is the blank pattern.
- States are IDLE, RUN, PAUSE, DONE.
- Priority per cycle is stop > pause > start > period_ld.
- IDLE:
  - step held at 0, prescaler at 0.
  - period_ld=1 loads period_in; a value of 0 is stored as 1.
  - start=1 latches oneshot into mode and moves to RUN next cycle with prescaler=0 and step=0.
- RUN:
  - The prescaler increments each cycle.
  - When prescaler==period-1: prescaler<=0, step_tick<=1, and the step advances.
  - Advance rule: if step<NUM_STEPS-1 then step<=step+1.
  - At wrap in loop mode, step<=0.
  - At wrap in one-shot mode, step<=0, state<=DONE and done<=1 in the same cycle as step_tick.
  - First advance occurs exactly `period` cycles after entering RUN. Step period is exactly `period` cycles.
- PAUSE:
  - Entered from RUN while pause=1; returns to RUN the cycle after pause=0.
  - Prescaler and step are frozen, and no tick is issued.
  - Resume continues from the frozen prescaler value, with no extra or lost cycles.
- DONE:
  - step=0, active=0.
  - start=1 restarts as from IDLE (re-samples oneshot).
  - stop=1 returns to IDLE.
- stop=1 in any state: next cycle state=IDLE, step=0, prescaler=0, and no tick or done pulse that cycle, even if a tick coincided.
- pause=1 and a tick coinciding: pause wins; the tick is deferred until resume.
- start held high in RUN is ignored. start and stop together gives IDLE.
- period_ld outside IDLE is ignored, so the period register is never changed mid-playback.
- period=1 gives a step_tick every RUN cycle.
- Reset asserted mid-playback: immediate return to reset values; no done pulse.

Test Plan:
- Reset values: PRESC_W=4, DEFAULT_PERIOD=3. Assert rst_n=0 mid-RUN -> step=0, active=0 and state IDLE immediately (asynchronous), with no done pulse.
- Loop playback: start=1 one cycle, oneshot=0 -> step reads 0,1,...,11,0,1 with each value held 3 cycles. step_tick pulses every 3rd cycle, first one 3 cycles after RUN entry. done never pulses.
- One-shot: oneshot=1, start -> 12 ticks, then done=1 for one cycle coincident with the 12th tick, step=0, active=0. Then start again -> playback restarts.
- Pause: in RUN at step=5 with prescaler=1, hold pause 10 cycles -> step stays 5 with no ticks. After release, the next tick arrives 2 cycles later and step=6.
- Stop priority: stop asserted in the same cycle as a tick at step=7 -> next cycle step=0, IDLE, and no step_tick. Stop with pause high at the same time -> also IDLE.
- Period load: period_ld with period_in=0 in IDLE -> period=1, ticks every cycle. period_ld with period_in=5 during RUN -> ignored, period stays unchanged until back in IDLE.
